// File: rtl/ffo32_drain_pkg.sv
// ffo32_drain_pkg: shared widths, state encoding and mask/index types for the drain sequencer.
package ffo32_drain_pkg;
    localparam int N = 32;
    localparam int IDXW = $clog2(N);
    typedef enum logic {IDLE, DRAIN} drain_state_t;
    typedef logic [0:N-1] mask_t;
    typedef logic [0:IDXW-1] idx_t;
endpackage

// File: rtl/ffo32_drain_if.sv
// ffo32_drain_if: mask-in and index-out valid/ready channels of the drain sequencer.
interface ffo32_drain_if;
    import ffo32_drain_pkg::*;
    logic in_valid;
    logic in_ready;
    mask_t in_mask;
    logic out_valid;
    logic out_ready;
    idx_t out_idx;
    logic out_last;
    logic out_empty;
    modport master (
        output in_valid, in_mask, out_ready,
        input in_ready, out_valid, out_idx, out_last, out_empty
    );
    modport slave (
        input in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_empty
    );
endinterface

// File: rtl/ffo32_drain_ffo_tree.sv
// ffo_tree: combinational find-first-one as a recursive LZD merge tree; bit 0 wins.
// p is meaningless when v=0.
module ffo_tree #(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input logic [0:N-1] b,
    output logic v,
    output logic [0:W-1] p
);
    generate
        if (N == 2) begin : g_leaf
            assign v = b[0] | b[1];
            assign p = ~b[0];
        end else begin : g_node
            logic vl, vr;
            logic [0:W-2] pl, pr;
            ffo_tree #(.N(N / 2)) u_l (.b(b[0:N/2-1]), .v(vl), .p(pl));
            ffo_tree #(.N(N / 2)) u_r (.b(b[N/2:N-1]), .v(vr), .p(pr));
            assign v = vl | vr;
            assign p = vl ? {1'b0, pl} : {1'b1, pr};
        end
    endgenerate
endmodule

// File: rtl/ffo32_drain.sv
// ffo32_drain: loads a request mask and emits the index of every set bit, lowest index first.
module ffo32_drain
    import ffo32_drain_pkg::*;
(
    input logic clock,
    input logic reset_n,
    ffo32_drain_if.slave bus,
    output logic busy,
    output logic [15:0] words_done
);
    drain_state_t state, state_nx;
    mask_t residual, residual_nx, onehot;
    logic v, drain, accept, last, load;
    idx_t p;
    ffo_tree #(.N(N)) u_tree (.b(residual), .v(v), .p(p));
    always_comb begin
        onehot = '0;
        onehot[p] = v;
    end
    // Outputs depend only on the residual, gated so IDLE and reset show all zeros.
    assign drain = (state == DRAIN);
    assign last = ((residual & ~onehot) == '0);
    assign accept = drain & bus.out_ready;
    assign bus.out_valid = drain;
    assign bus.out_idx = (drain & v) ? p : '0;
    assign bus.out_empty = drain & ~v;
    assign bus.out_last = drain & last;
    assign bus.in_ready = ~drain | (accept & last);
    assign busy = drain;
    assign load = bus.in_valid & bus.in_ready;
    always_comb begin
        state_nx = load ? DRAIN : (accept & last) ? IDLE : state;
        residual_nx = load ? bus.in_mask : accept ? (last ? '0 : residual & ~onehot) : residual;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            residual <= '0;
            words_done <= '0;
        end else begin
            state <= state_nx;
            residual <= residual_nx;
            words_done <= words_done + {15'd0, accept & last};
        end
    end
endmodule

// File: tb/tb_ffo32_drain.sv
// tb_ffo32_drain: directed scenarios for the mask drain sequencer with hand-computed indices.
module tb_ffo32_drain;
    import ffo32_drain_pkg::*;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic [15:0] words_done;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_wd = '0;
    ffo32_drain_if bus ();
    ffo32_drain dut (.clock(clock), .reset_n(reset_n), .bus(bus), .busy(busy), .words_done(words_done));
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mask = 32'hFFFF_FFFF;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (words_done !== 16'd0) begin errors++; $display("FAIL rst_wd got %0d want 0", words_done); end
        checks++; if ({bus.out_idx, bus.out_last, bus.out_empty} !== 7'd0) begin errors++; $display("FAIL rst_outs got %0d/%b/%b want 0/0/0", bus.out_idx, bus.out_last, bus.out_empty); end
        bus.in_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got %b want 0", bus.out_valid); end
    endtask

    task automatic test_two_bits();
        bus.in_valid = 1'b1;
        bus.in_mask = 32'h8000_0001;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_mask = 32'h0;
        checks++; if ({bus.out_valid, busy, bus.out_idx, bus.out_last} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL two_beat0 got v=%b busy=%b idx=%0d last=%b want 1 1 0 0", bus.out_valid, busy, bus.out_idx, bus.out_last); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL two_in_ready got %b want 0", bus.in_ready); end
        step();
        checks++; if ({bus.out_valid, bus.out_idx, bus.out_last, bus.out_empty} !== {1'b1, 5'd31, 1'b1, 1'b0}) begin errors++; $display("FAIL two_beat1 got v=%b idx=%0d last=%b empty=%b want 1 31 1 0", bus.out_valid, bus.out_idx, bus.out_last, bus.out_empty); end
        step();
        exp_wd++;
        checks++; if ({bus.out_valid, busy} !== 2'b00) begin errors++; $display("FAIL two_idle got v=%b busy=%b want 0 0", bus.out_valid, busy); end
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL two_wd got %0d want %0d", words_done, exp_wd); end
    endtask

    task automatic test_empty();
        bus.in_valid = 1'b1;
        bus.in_mask = 32'h0;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_empty, bus.out_last, bus.out_idx} !== {1'b1, 1'b1, 1'b1, 5'd0}) begin errors++; $display("FAIL empty_beat got v=%b empty=%b last=%b idx=%0d want 1 1 1 0", bus.out_valid, bus.out_empty, bus.out_last, bus.out_idx); end
        step();
        exp_wd++;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_single got %b want 0", bus.out_valid); end
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL empty_wd got %0d want %0d", words_done, exp_wd); end
    endtask

    task automatic test_stall();
        bus.in_valid = 1'b1;
        bus.in_mask = 32'hFFFF_FFFF;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_mask = 32'h0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checks++; if ({bus.out_valid, bus.out_idx, bus.out_last} !== {1'b1, 5'(i), i == 31}) begin errors++; $display("FAIL stall_beat%0d got v=%b idx=%0d last=%b", i, bus.out_valid, bus.out_idx, bus.out_last); end
            step();
            checks++; if ({bus.out_idx, bus.out_last} !== {5'(i), i == 31}) begin errors++; $display("FAIL stall_hold%0d got idx=%0d last=%b want %0d", i, bus.out_idx, bus.out_last, i); end
            bus.out_ready = 1'b1;
            #1;
            checks++; if (bus.in_ready !== (i == 31)) begin errors++; $display("FAIL stall_in_ready%0d got %b want %b", i, bus.in_ready, i == 31); end
            step();
            bus.out_ready = 1'b0;
        end
        exp_wd++;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %b want 0", bus.out_valid); end
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL stall_wd got %0d want %0d", words_done, exp_wd); end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1;
        bus.in_mask = 32'h4000_0000;
        bus.out_ready = 1'b1;
        step();
        bus.in_mask = 32'h0000_0002;
        checks++; if ({bus.out_idx, bus.out_last, bus.in_ready} !== {5'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL b2b_first got idx=%0d last=%b in_ready=%b want 1 1 1", bus.out_idx, bus.out_last, bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_idx, bus.out_last} !== {1'b1, 5'd30, 1'b1}) begin errors++; $display("FAIL b2b_second got v=%b idx=%0d last=%b want 1 30 1", bus.out_valid, bus.out_idx, bus.out_last); end
        step();
        exp_wd += 2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.out_valid); end
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL b2b_wd got %0d want %0d", words_done, exp_wd); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_mask = 32'hFF00_0000;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_mask = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_idx !== 5'(i)) begin errors++; $display("FAIL mid_beat%0d got %0d want %0d", i, bus.out_idx, i); end
            step();
        end
        #1;
        reset_n = 1'b0;
        #1;
        exp_wd = '0;
        checks++; if ({bus.out_valid, busy, bus.out_idx, bus.out_last, bus.out_empty} !== 9'd0) begin errors++; $display("FAIL mid_async got v=%b busy=%b idx=%0d last=%b empty=%b want all 0", bus.out_valid, busy, bus.out_idx, bus.out_last, bus.out_empty); end
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL mid_wd got %0d want 0", words_done); end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b want 0", bus.out_valid); end
        bus.in_valid = 1'b1;
        bus.in_mask = 32'h0100_0000;
        step();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_idx, bus.out_last} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL mid_next got v=%b idx=%0d last=%b want 1 7 1", bus.out_valid, bus.out_idx, bus.out_last); end
        step();
        exp_wd++;
        checks++; if (words_done !== exp_wd) begin errors++; $display("FAIL mid_next_wd got %0d want %0d", words_done, exp_wd); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_mask = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_two_bits();
        test_empty();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
